// File: rtl/rm_lane_event_accum.sv
// -----------------------------------------------------------------------------
// rm_lane_event_accum
//
// Routes NUM_EVENTS probe hits onto NUM_LANES output lanes, registers the
// per-lane routed vectors, and keeps a saturating event counter per lane with
// a one-cycle threshold-crossing pulse.
//
// Each event carries a destination lane index. A probe hit is delivered only
// to an in-range, enabled lane. A per-event lane-reset request clears its
// destination lane's counter whether or not that lane is enabled. A probe or
// lane-reset request aimed at a lane index outside the lane range is dropped,
// and it sets a sticky error flag that only rst_i clears.
//
// Ports
//   clk_i          clock, all state on the rising edge
//   rst_i          synchronous active-high reset, overrides every other input
//   probe_val_i    [NUM_EVENTS]         probe hit per event this cycle
//   lane_sel_i     [NUM_EVENTS*LANE_W]  destination lane per event, event i at
//                                       bits [i*LANE_W +: LANE_W]
//   reset_lane_i   [NUM_EVENTS]         per-event request to reset its lane
//   lane_en_i      [NUM_LANES]          lane enable mask
//   thresh_i       [CNT_W]              shared hit threshold, 0 disables hits
//   lane_vector_o  [NUM_LANES*NUM_EVENTS] registered routed vector, lane L at
//                                       bits [L*NUM_EVENTS +: NUM_EVENTS]
//   lane_reset_o   [NUM_LANES]          registered per-lane reset pulse
//   lane_cnt_o     [NUM_LANES*CNT_W]    saturating count, lane L at
//                                       bits [L*CNT_W +: CNT_W]
//   lane_hit_o     [NUM_LANES]          one-cycle threshold-crossing pulse
//   route_err_o                         sticky out-of-range routing flag
// -----------------------------------------------------------------------------
module rm_lane_event_accum #(
   parameter int NUM_LANES  = 5,
   parameter int NUM_EVENTS = 10,
   parameter int CNT_W      = 16,
   localparam int LANE_W    = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
   input  logic                            clk_i,
   input  logic                            rst_i,
   input  logic [NUM_EVENTS-1:0]           probe_val_i,
   input  logic [NUM_EVENTS*LANE_W-1:0]    lane_sel_i,
   input  logic [NUM_EVENTS-1:0]           reset_lane_i,
   input  logic [NUM_LANES-1:0]            lane_en_i,
   input  logic [CNT_W-1:0]                thresh_i,
   output logic [NUM_LANES*NUM_EVENTS-1:0] lane_vector_o,
   output logic [NUM_LANES-1:0]            lane_reset_o,
   output logic [NUM_LANES*CNT_W-1:0]      lane_cnt_o,
   output logic [NUM_LANES-1:0]            lane_hit_o,
   output logic                            route_err_o
);

   // The increment can reach NUM_EVENTS, so the sum gets enough headroom that
   // saturation is decided before any bits are lost.
   localparam int INC_W = $clog2(NUM_EVENTS + 1);
   localparam int SUM_W = CNT_W + INC_W;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [NUM_LANES*NUM_EVENTS-1:0] vec_d, vec_q;
   logic [NUM_LANES-1:0]            rst_req_d, rst_req_q;
   logic [NUM_LANES*CNT_W-1:0]      cnt_d, cnt_q;
   logic [NUM_LANES-1:0]            hit_d, hit_q;
   logic                            err_now_d, err_q;

   int                              sel_idx;
   logic [INC_W-1:0]                inc_v;
   logic [SUM_W-1:0]                sum_v;
   logic [CNT_W-1:0]                cnt_old_v;
   logic [CNT_W-1:0]                cnt_new_v;

   // Routing: decode every event's destination once and fan it out to lanes.
   always_comb begin
      vec_d     = '0;
      rst_req_d = '0;
      err_now_d = 1'b0;
      sel_idx   = 0;
      for (int i = 0; i < NUM_EVENTS; i++) begin
         sel_idx = int'(lane_sel_i[i*LANE_W +: LANE_W]);
         for (int l = 0; l < NUM_LANES; l++) begin
            if (sel_idx == l) begin
               // Lane reset requests ignore the enable mask.
               if (reset_lane_i[i]) begin
                  rst_req_d[l] = 1'b1;
               end
               if (probe_val_i[i] && lane_en_i[l]) begin
                  vec_d[l*NUM_EVENTS + i] = 1'b1;
               end
            end
         end
         if ((sel_idx >= NUM_LANES) && (probe_val_i[i] || reset_lane_i[i])) begin
            err_now_d = 1'b1;
         end
      end
   end

   // Counting: popcount of this cycle's routed vector, saturating add, and a
   // hit only on the transition from below threshold to at/above it.
   always_comb begin
      cnt_d     = '0;
      hit_d     = '0;
      inc_v     = '0;
      sum_v     = '0;
      cnt_old_v = '0;
      cnt_new_v = '0;
      for (int l = 0; l < NUM_LANES; l++) begin
         inc_v = '0;
         for (int i = 0; i < NUM_EVENTS; i++) begin
            inc_v = inc_v + INC_W'(vec_d[l*NUM_EVENTS + i]);
         end
         cnt_old_v = cnt_q[l*CNT_W +: CNT_W];
         sum_v     = SUM_W'(cnt_old_v) + SUM_W'(inc_v);
         if (rst_req_d[l]) begin
            cnt_new_v = '0;
         end else if (sum_v > SUM_W'(CNT_MAX)) begin
            cnt_new_v = CNT_MAX;
         end else begin
            cnt_new_v = sum_v[CNT_W-1:0];
         end
         cnt_d[l*CNT_W +: CNT_W] = cnt_new_v;
         // A reset cycle never fires; a threshold change with an unchanged
         // count cannot fire because old and new counts are equal.
         hit_d[l] = !rst_req_d[l] && (thresh_i != '0) &&
                    (cnt_old_v < thresh_i) && (cnt_new_v >= thresh_i);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         vec_q     <= '0;
         rst_req_q <= '0;
         cnt_q     <= '0;
         hit_q     <= '0;
         err_q     <= 1'b0;
      end else begin
         vec_q     <= vec_d;
         rst_req_q <= rst_req_d;
         cnt_q     <= cnt_d;
         hit_q     <= hit_d;
         err_q     <= err_q | err_now_d;
      end
   end

   assign lane_vector_o = vec_q;
   assign lane_reset_o  = rst_req_q;
   assign lane_cnt_o    = cnt_q;
   assign lane_hit_o    = hit_q;
   assign route_err_o   = err_q;

endmodule

// File: tb/tb_rm_lane_event_accum.sv
// -----------------------------------------------------------------------------
// Bench for rm_lane_event_accum. The main instance uses the default
// parameters; a second instance with CNT_W=2 shares the same stimulus and is
// used for saturation checks.
// -----------------------------------------------------------------------------
module tb_rm_lane_event_accum;

   localparam int NL = 5;
   localparam int NE = 10;
   localparam int CW = 16;
   localparam int LW = 3;

   logic              clk;
   logic              rst;
   logic [NE-1:0]     probe;
   logic [NE*LW-1:0]  sel;
   logic [NE-1:0]     rlane;
   logic [NL-1:0]     en;
   logic [CW-1:0]     thresh;

   logic [NL*NE-1:0]  vec;
   logic [NL-1:0]     lreset;
   logic [NL*CW-1:0]  cnt;
   logic [NL-1:0]     hit;
   logic              err;

   logic [NL*NE-1:0]  vec2;
   logic [NL-1:0]     lreset2;
   logic [NL*2-1:0]   cnt2;
   logic [NL-1:0]     hit2;
   logic              err2;

   int total = 0;
   int bad   = 0;

   rm_lane_event_accum #(.NUM_LANES(NL), .NUM_EVENTS(NE), .CNT_W(CW)) u_dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .probe_val_i   (probe),
      .lane_sel_i    (sel),
      .reset_lane_i  (rlane),
      .lane_en_i     (en),
      .thresh_i      (thresh),
      .lane_vector_o (vec),
      .lane_reset_o  (lreset),
      .lane_cnt_o    (cnt),
      .lane_hit_o    (hit),
      .route_err_o   (err)
   );

   rm_lane_event_accum #(.NUM_LANES(NL), .NUM_EVENTS(NE), .CNT_W(2)) u_dut2 (
      .clk_i         (clk),
      .rst_i         (rst),
      .probe_val_i   (probe),
      .lane_sel_i    (sel),
      .reset_lane_i  (rlane),
      .lane_en_i     (en),
      .thresh_i      (thresh[1:0]),
      .lane_vector_o (vec2),
      .lane_reset_o  (lreset2),
      .lane_cnt_o    (cnt2),
      .lane_hit_o    (hit2),
      .route_err_o   (err2)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // helpers
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_sel(input int i, input int l);
      sel[i*LW +: LW] = LW'(l);
   endtask

   function automatic logic [CW-1:0] c1(input int l);
      return cnt[l*CW +: CW];
   endfunction

   function automatic logic [1:0] c2(input int l);
      return cnt2[l*2 +: 2];
   endfunction

   // tests
   task automatic test_reset();
      rst = 1'b1;
      step();
      step();
      total++; if (vec !== '0)    begin bad++; $display("FAIL reset_vec got=%h exp=0", vec); end
      total++; if (lreset !== '0) begin bad++; $display("FAIL reset_lreset got=%b exp=0", lreset); end
      total++; if (cnt !== '0)    begin bad++; $display("FAIL reset_cnt got=%h exp=0", cnt); end
      total++; if (hit !== '0)    begin bad++; $display("FAIL reset_hit got=%b exp=0", hit); end
      total++; if (err !== 1'b0)  begin bad++; $display("FAIL reset_err got=%b exp=0", err); end
      rst = 1'b0;
   endtask

   task automatic test_route();
      sel = '0;
      set_sel(0, 2);
      set_sel(2, 2);
      probe = 10'h005;
      step();
      total++; if (vec !== (50'h005 << 20)) begin bad++; $display("FAIL route_vec got=%h exp=%h", vec, 50'h005 << 20); end
      total++; if (c1(2) !== 16'd2) begin bad++; $display("FAIL route_cnt2 got=%0d exp=2", c1(2)); end
      for (int l = 0; l < NL; l++) begin
         if (l != 2) begin
            total++; if (c1(l) !== 16'd0) begin bad++; $display("FAIL route_cnt_other lane=%0d got=%0d exp=0", l, c1(l)); end
         end
      end
      probe = '0;
      step();
      total++; if (vec !== '0) begin bad++; $display("FAIL route_idle_vec got=%h exp=0", vec); end
      total++; if (c1(2) !== 16'd2) begin bad++; $display("FAIL route_hold_cnt2 got=%0d exp=2", c1(2)); end
      rlane = 10'h001;
      step();
      total++; if (lreset !== 5'b00100) begin bad++; $display("FAIL route_lreset got=%b exp=00100", lreset); end
      total++; if (c1(2) !== 16'd0) begin bad++; $display("FAIL route_clr_cnt2 got=%0d exp=0", c1(2)); end
      rlane = '0;
      step();
      total++; if (lreset !== 5'b00000) begin bad++; $display("FAIL route_lreset_pulse got=%b exp=00000", lreset); end
   endtask

   task automatic test_threshold();
      logic [NL-1:0] exp_hit;
      sel = '0;
      set_sel(0, 1);
      thresh = 16'd3;
      probe  = 10'h001;
      for (int k = 1; k <= 4; k++) begin
         step();
         exp_hit = (k == 3) ? 5'b00010 : 5'b00000;
         total++; if (c1(1) !== 16'(k)) begin bad++; $display("FAIL thr_cnt k=%0d got=%0d exp=%0d", k, c1(1), k); end
         total++; if (hit !== exp_hit) begin bad++; $display("FAIL thr_hit k=%0d got=%b exp=%b", k, hit, exp_hit); end
      end
      // Raising the threshold to the current count must not fire.
      probe  = '0;
      thresh = 16'd4;
      step();
      total++; if (hit !== 5'b0) begin bad++; $display("FAIL thr_change_hit got=%b exp=0", hit); end
      total++; if (c1(1) !== 16'd4) begin bad++; $display("FAIL thr_change_cnt got=%0d exp=4", c1(1)); end
      rlane  = 10'h001;
      thresh = '0;
      step();
      total++; if (c1(1) !== 16'd0) begin bad++; $display("FAIL thr_clr_cnt got=%0d exp=0", c1(1)); end
      rlane = '0;
      // Threshold zero: counting runs, no hit.
      probe = 10'h001;
      for (int k = 1; k <= 2; k++) begin
         step();
         total++; if (hit !== 5'b0) begin bad++; $display("FAIL thr_zero_hit k=%0d got=%b exp=0", k, hit); end
      end
      probe = '0;
      rlane = 10'h001;
      step();
      rlane = '0;
   endtask

   task automatic test_saturate();
      sel   = '0;
      rlane = 10'h001;
      probe = '0;
      step();
      rlane = '0;
      probe = 10'h007;
      step();
      total++; if (c2(0) !== 2'd3)  begin bad++; $display("FAIL sat_cnt_c1 got=%0d exp=3", c2(0)); end
      total++; if (c1(0) !== 16'd3) begin bad++; $display("FAIL sat_wide_c1 got=%0d exp=3", c1(0)); end
      step();
      total++; if (c2(0) !== 2'd3)  begin bad++; $display("FAIL sat_cnt_c2 got=%0d exp=3", c2(0)); end
      total++; if (c1(0) !== 16'd6) begin bad++; $display("FAIL sat_wide_c2 got=%0d exp=6", c1(0)); end
      rlane = 10'h001;
      step();
      total++; if (c2(0) !== 2'd0)   begin bad++; $display("FAIL sat_reset_cnt got=%0d exp=0", c2(0)); end
      total++; if (c1(0) !== 16'd0)  begin bad++; $display("FAIL sat_reset_wide got=%0d exp=0", c1(0)); end
      total++; if (lreset !== 5'b00001)  begin bad++; $display("FAIL sat_lreset got=%b exp=00001", lreset); end
      total++; if (lreset2 !== 5'b00001) begin bad++; $display("FAIL sat_lreset2 got=%b exp=00001", lreset2); end
      rlane = '0;
      probe = '0;
      step();
      total++; if (lreset !== 5'b00000) begin bad++; $display("FAIL sat_lreset_pulse got=%b exp=00000", lreset); end
      total++; if (c2(0) !== 2'd0) begin bad++; $display("FAIL sat_after_cnt got=%0d exp=0", c2(0)); end
   endtask

   task automatic test_disabled();
      en  = 5'b11101;
      sel = '0;
      set_sel(0, 1);
      set_sel(1, 3);
      probe = 10'h003;
      step();
      total++; if (vec !== (50'h1 << 31)) begin bad++; $display("FAIL dis_vec got=%h exp=%h", vec, 50'h1 << 31); end
      total++; if (c1(1) !== 16'd0) begin bad++; $display("FAIL dis_cnt1 got=%0d exp=0", c1(1)); end
      total++; if (c1(3) !== 16'd1) begin bad++; $display("FAIL dis_cnt3 got=%0d exp=1", c1(3)); end
      total++; if (err !== 1'b0) begin bad++; $display("FAIL dis_err got=%b exp=0", err); end
      // Lane reset reaches the disabled lane too.
      probe = '0;
      rlane = 10'h003;
      step();
      total++; if (lreset !== 5'b01010) begin bad++; $display("FAIL dis_lreset got=%b exp=01010", lreset); end
      total++; if (c1(3) !== 16'd0) begin bad++; $display("FAIL dis_clr_cnt3 got=%0d exp=0", c1(3)); end
      rlane = '0;
      en    = 5'b11111;
   endtask

   task automatic test_route_err();
      total++; if (err !== 1'b0) begin bad++; $display("FAIL err_pre got=%b exp=0", err); end
      sel = '0;
      set_sel(4, 6);
      probe = 10'h010;
      step();
      total++; if (err !== 1'b1) begin bad++; $display("FAIL err_set got=%b exp=1", err); end
      total++; if (vec !== '0) begin bad++; $display("FAIL err_vec got=%h exp=0", vec); end
      for (int l = 0; l < NL; l++) begin
         total++; if (c1(l) !== 16'd0) begin bad++; $display("FAIL err_cnt lane=%0d got=%0d exp=0", l, c1(l)); end
      end
      probe = '0;
      step();
      total++; if (err !== 1'b1) begin bad++; $display("FAIL err_sticky got=%b exp=1", err); end
      sel = '0;
   endtask

   task automatic test_mid_reset();
      sel = '0;
      set_sel(0, 4);
      probe = 10'h001;
      step();
      total++; if (c1(4) !== 16'd1) begin bad++; $display("FAIL mid_cnt_a got=%0d exp=1", c1(4)); end
      step();
      total++; if (c1(4) !== 16'd2) begin bad++; $display("FAIL mid_cnt_b got=%0d exp=2", c1(4)); end
      rst = 1'b1;
      step();
      total++; if (vec !== '0)    begin bad++; $display("FAIL mid_vec got=%h exp=0", vec); end
      total++; if (lreset !== '0) begin bad++; $display("FAIL mid_lreset got=%b exp=0", lreset); end
      total++; if (cnt !== '0)    begin bad++; $display("FAIL mid_cnt got=%h exp=0", cnt); end
      total++; if (hit !== '0)    begin bad++; $display("FAIL mid_hit got=%b exp=0", hit); end
      total++; if (err !== 1'b0)  begin bad++; $display("FAIL mid_err got=%b exp=0", err); end
      rst = 1'b0;
      step();
      total++; if (c1(4) !== 16'd1) begin bad++; $display("FAIL mid_resume_cnt got=%0d exp=1", c1(4)); end
      total++; if (vec !== (50'h1 << 40)) begin bad++; $display("FAIL mid_resume_vec got=%h exp=%h", vec, 50'h1 << 40); end
      probe = '0;
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < NE; i++) set_sel(i, 3);
      probe  = 10'h3ff;
      thresh = 16'd15;
      step();
      total++; if (vec !== (50'h3ff << 30)) begin bad++; $display("FAIL b2b_vec got=%h exp=%h", vec, 50'h3ff << 30); end
      total++; if (c1(3) !== 16'd10) begin bad++; $display("FAIL b2b_cnt1 got=%0d exp=10", c1(3)); end
      total++; if (hit !== 5'b00000) begin bad++; $display("FAIL b2b_hit1 got=%b exp=00000", hit); end
      step();
      total++; if (c1(3) !== 16'd20) begin bad++; $display("FAIL b2b_cnt2 got=%0d exp=20", c1(3)); end
      total++; if (hit !== 5'b01000) begin bad++; $display("FAIL b2b_hit2 got=%b exp=01000", hit); end
      step();
      total++; if (c1(3) !== 16'd30) begin bad++; $display("FAIL b2b_cnt3 got=%0d exp=30", c1(3)); end
      total++; if (hit !== 5'b00000) begin bad++; $display("FAIL b2b_hit3 got=%b exp=00000", hit); end
      probe  = '0;
      thresh = '0;
      step();
   endtask

   initial begin
      rst    = 1'b1;
      probe  = '0;
      sel    = '0;
      rlane  = '0;
      en     = 5'b11111;
      thresh = '0;
      test_reset();
      test_route();
      test_threshold();
      test_saturate();
      test_disabled();
      test_route_err();
      test_mid_reset();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
